hub75_scan_ctrl: RTL and testbench

Sequencer that feeds the HUB75 panel shift chain in step with the binary-coded-modulation (BCM) display timer. For each row and bit-plane it reads a row of pixels from the framebuffer and shifts one bit-plane out on the RGB/SCLK lines. It pulses LAT at the start of each timer blanking interval and enables the timer after the first plane is loaded. It sits between the framebuffer read port and the panel pins, alongside the display timer, which owns OE_n and row select.

---
 rtl/hub75_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 shift-chain sequencer: reads one framebuffer row per bit-plane, shifts it out on RGB/SCLK
// and latches it at each blanking edge of the BCM display timer.
module hub75_scan_ctrl #(
  parameter int unsigned hpixel_p   = 64,
  parameter int unsigned vpixel_p   = 64,
  parameter int unsigned bpp_p      = 8,
  parameter int unsigned segments_p = 2
) (
  input  logic                                                      clk,
  input  logic                                                      rst_n,
  input  logic                                                      i_enable,
  input  logic [2*bpp_p-1:0]                                        i_base_wait,
  input  logic [2*bpp_p-1:0]                                        i_blank_interval,
  input  logic                                                      i_oe_n,
  output logic                                                      o_timer_en,
  output logic [2*bpp_p-1:0]                                        o_base_wait,
  output logic [2*bpp_p-1:0]                                        o_blank_interval,
  output logic                                                      o_fb_rd,
  output logic [$clog2(vpixel_p/segments_p)+$clog2(hpixel_p)-1:0]   o_fb_addr,
  input  logic [segments_p*3*bpp_p-1:0]                             i_fb_data,
  output logic [3*segments_p-1:0]                                   o_rgb,
  output logic                                                      o_sclk,
  output logic                                                      o_latch,
  output logic                                                      o_underrun
);

  localparam int unsigned Rows   = vpixel_p / segments_p;
  localparam int unsigned RowW   = $clog2(Rows);
  localparam int unsigned ColW   = $clog2(hpixel_p);
  localparam int unsigned PlaneW = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int unsigned TW     = $clog2(2 * hpixel_p + 1);
  localparam logic [TW-1:0] LastT = TW'(2 * hpixel_p);

  typedef enum logic [1:0] {StIdle, StShift, StWaitBlank, StLatch} state_e;

  state_e              state_q;
  logic [TW-1:0]       t_q;
  logic [RowW-1:0]     row_q;
  logic [PlaneW-1:0]   plane_q;
  logic                first_q;
  logic                pend_q;
  logic                oe_q;

  logic                blank_edge;
  logic [TW-1:0]       t_nxt;
  logic                plane_last;
  logic [PlaneW-1:0]   plane_nxt;
  logic [RowW-1:0]     row_nxt;
  logic [3*segments_p-1:0] rgb_nxt;

  always_comb begin
    blank_edge = i_oe_n & ~oe_q & o_timer_en;
    t_nxt      = t_q + TW'(1);
    plane_last = (plane_q == PlaneW'(bpp_p - 1));
    plane_nxt  = plane_last ? '0 : plane_q + PlaneW'(1);
    row_nxt    = row_q;
    if (plane_last) begin
      row_nxt = (row_q == RowW'(Rows - 1)) ? '0 : row_q + RowW'(1);
    end
    rgb_nxt = '0;
    for (int i = 0; i < 3 * segments_p; i++) begin
      rgb_nxt[i] = i_fb_data[i * bpp_p + int'(plane_q)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      t_q              <= '0;
      row_q            <= '0;
      plane_q          <= '0;
      first_q          <= 1'b0;
      pend_q           <= 1'b0;
      oe_q             <= 1'b1;
      o_timer_en       <= 1'b0;
      o_base_wait      <= '0;
      o_blank_interval <= '0;
      o_fb_rd          <= 1'b0;
      o_fb_addr        <= '0;
      o_rgb            <= '0;
      o_sclk           <= 1'b0;
      o_latch          <= 1'b0;
      o_underrun       <= 1'b0;
    end else begin
      oe_q <= i_oe_n;
      if (!i_enable) begin
        // Config registers deliberately hold across disable.
        state_q    <= StIdle;
        t_q        <= '0;
        row_q      <= '0;
        plane_q    <= '0;
        first_q    <= 1'b0;
        pend_q     <= 1'b0;
        o_timer_en <= 1'b0;
        o_fb_rd    <= 1'b0;
        o_fb_addr  <= '0;
        o_rgb      <= '0;
        o_sclk     <= 1'b0;
        o_latch    <= 1'b0;
        if (state_q == StIdle) o_underrun <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            o_underrun       <= 1'b0;
            o_base_wait      <= i_base_wait;
            o_blank_interval <= i_blank_interval;
            row_q            <= '0;
            plane_q          <= '0;
            first_q          <= 1'b1;
            pend_q           <= 1'b0;
            t_q              <= '0;
            o_fb_addr        <= '0;
            o_fb_rd          <= 1'b1;
            o_sclk           <= 1'b0;
            o_latch          <= 1'b0;
            state_q          <= StShift;
          end
          StShift: begin
            if (t_q[0]) o_rgb <= rgb_nxt;
            if (blank_edge) begin
              o_underrun <= 1'b1;
              pend_q     <= 1'b1;
            end
            if (t_q == LastT) begin
              t_q     <= '0;
              o_fb_rd <= 1'b0;
              o_sclk  <= 1'b0;
              // A blank edge already seen (or arriving now) means the timer is ahead: latch at once.
              if (first_q || pend_q || blank_edge) begin
                state_q <= StLatch;
                o_latch <= 1'b1;
                first_q <= 1'b0;
                pend_q  <= 1'b0;
              end else begin
                state_q <= StWaitBlank;
              end
            end else begin
              t_q       <= t_nxt;
              o_fb_rd   <= ~t_nxt[0] && (t_nxt != LastT);
              o_sclk    <= ~t_nxt[0];
              o_fb_addr <= {row_q, t_nxt[ColW:1]};
            end
          end
          StWaitBlank: begin
            if (blank_edge) begin
              state_q <= StLatch;
              o_latch <= 1'b1;
            end
          end
          StLatch: begin
            o_latch    <= 1'b0;
            o_timer_en <= 1'b1;
            plane_q    <= plane_nxt;
            row_q      <= row_nxt;
            o_fb_addr  <= {row_nxt, ColW'(0)};
            o_fb_rd    <= 1'b1;
            t_q        <= '0;
            state_q    <= StShift;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl on an 8x8, 2-plane, 2-segment panel with framebuffer and
// display-timer models; a per-cycle monitor cross-checks latch ordering and shifted data.
module tb_hub75_scan_ctrl;

  localparam int H = 8;
  localparam int V = 8;
  localparam int BPP = 2;
  localparam int SEG = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [3:0]  i_base_wait = '0;
  logic [3:0]  i_blank_interval = '0;
  logic        i_oe_n;
  logic        o_timer_en;
  logic [3:0]  o_base_wait;
  logic [3:0]  o_blank_interval;
  logic        o_fb_rd;
  logic [4:0]  o_fb_addr;
  logic [11:0] i_fb_data;
  logic [5:0]  o_rgb;
  logic        o_sclk;
  logic        o_latch;
  logic        o_underrun;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(
    .hpixel_p  (H),
    .vpixel_p  (V),
    .bpp_p     (BPP),
    .segments_p(SEG)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .i_base_wait     (i_base_wait),
    .i_blank_interval(i_blank_interval),
    .i_oe_n          (i_oe_n),
    .o_timer_en      (o_timer_en),
    .o_base_wait     (o_base_wait),
    .o_blank_interval(o_blank_interval),
    .o_fb_rd         (o_fb_rd),
    .o_fb_addr       (o_fb_addr),
    .i_fb_data       (i_fb_data),
    .o_rgb           (o_rgb),
    .o_sclk          (o_sclk),
    .o_latch         (o_latch),
    .o_underrun      (o_underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] fb_word(input logic [4:0] a);
    return 12'(a * 149) ^ 12'hA5C;
  endfunction

  function automatic logic [5:0] exp_rgb(input logic [11:0] w, input int p);
    logic [5:0] r;
    for (int s = 0; s < SEG; s++)
      for (int k = 0; k < 3; k++) r[s*3+k] = w[(s*3+k)*BPP + p];
    return r;
  endfunction

  // Framebuffer: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (o_fb_rd) i_fb_data <= fb_word(o_fb_addr);
    else         i_fb_data <= 12'hDB6;
  end

  // Display timer: OE_n high while disabled, then low tmr_d / high tmr_b periodically.
  logic use_model = 1'b0;
  logic man_req = 1'b1;
  int   tmr_d = 30;
  int   tmr_b = 4;
  int   tcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_oe_n <= 1'b1;
      tcnt   <= 0;
    end else if (!use_model) begin
      i_oe_n <= man_req;
      tcnt   <= 0;
    end else if (!o_timer_en) begin
      i_oe_n <= 1'b1;
      tcnt   <= 0;
    end else begin
      tcnt   <= (tcnt == tmr_d + tmr_b - 1) ? 0 : tcnt + 1;
      i_oe_n <= (((tcnt == tmr_d + tmr_b - 1) ? 0 : tcnt + 1) >= tmr_d);
    end
  end

  logic       oe_prev = 1'b1;
  logic       end_prev = 1'b0;
  logic       exp_lat = 1'b0;
  logic       waiting = 1'b0;
  logic       edge_wait_prev = 1'b0;
  logic       pend = 1'b0;
  logic [4:0] a_d1 = '0;
  logic [4:0] a_d2 = '0;
  int         exp_plane = 0;
  int         exp_row = 0;
  int         lat_cnt = 0;

  task automatic mon();
    logic blk_edge;
    logic send;
    blk_edge = i_oe_n && !oe_prev && o_timer_en;
    send     = o_sclk && !o_fb_rd;
    if (!i_enable) begin
      end_prev = 0; edge_wait_prev = 0; waiting = 0; pend = 0;
      exp_plane = 0; exp_row = 0;
    end else begin
      if (end_prev)       check("lat_after_shift", o_latch, exp_lat);
      if (edge_wait_prev) check("lat_after_blank", o_latch, 1);
      if (o_latch)        check("lat_vs_sclk", o_sclk, 0);
      if (o_fb_rd)        check("rd_row", o_fb_addr[4:3], exp_row);
      if (o_sclk)         check("rgb", o_rgb, exp_rgb(fb_word(a_d2), exp_plane));
      edge_wait_prev = waiting && blk_edge;
      if (edge_wait_prev) waiting = 0;
      end_prev = send;
      if (o_latch) begin
        pend = 0;
        lat_cnt++;
        if (exp_plane == BPP - 1) begin
          exp_plane = 0;
          exp_row = (exp_row + 1) % (V / SEG);
        end else begin
          exp_plane++;
        end
      end else if (blk_edge) begin
        pend = 1;
      end
      if (send) begin
        exp_lat = !o_timer_en || pend;
        waiting = !exp_lat;
      end
    end
    a_d2 = a_d1;
    a_d1 = o_fb_addr;
    oe_prev = i_oe_n;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  int n;

  initial begin
    // Reset and idle.
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {o_timer_en, o_fb_rd, o_sclk, o_latch, o_underrun, o_rgb, o_fb_addr,
                           o_base_wait, o_blank_interval}, 0);
    end
    rst_n = 1'b1;
    i_base_wait = 4'd9;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i % 5 == 0) check("idle_outs", {o_timer_en, o_sclk, o_latch, o_rgb, o_base_wait}, 0);
      check("idle_no_rd", o_fb_rd, 0);
    end

    // First plane after enable, cycle by cycle.
    use_model = 1'b1;
    tmr_d = 30; tmr_b = 4;
    i_base_wait = 4'd9;
    i_blank_interval = 4'd4;
    i_enable = 1'b1;
    for (int t = 0; t <= 2 * H; t++) begin
      cyc();
      check("sh_rd", o_fb_rd, (t % 2 == 0) && (t < 2 * H));
      if ((t % 2 == 0) && (t < 2 * H)) check("sh_addr", o_fb_addr, t / 2);
      check("sh_sclk", o_sclk, (t % 2 == 0) && (t >= 2));
      if ((t % 2 == 0) && (t >= 2)) check("sh_rgb", o_rgb, exp_rgb(fb_word(5'(t / 2 - 1)), 0));
      check("sh_latch", o_latch, 0);
      check("sh_ten", o_timer_en, 0);
    end
    cyc();
    check("first_lat", o_latch, 1);
    check("first_lat_sclk", o_sclk, 0);
    check("first_lat_ten", o_timer_en, 0);
    check("cap_base", o_base_wait, 9);
    check("cap_blank", o_blank_interval, 4);
    cyc();
    check("ten_rise", o_timer_en, 1);
    check("lat_one_cycle", o_latch, 0);
    check("p1_rd", o_fb_rd, 1);
    check("p1_addr", o_fb_addr, 0);

    // Free running against the timer model.
    repeat (400) cyc();
    check("free_underrun", o_underrun, 0);
    check("free_latches", lat_cnt >= 10, 1);
    check("free_ten", o_timer_en, 1);

    // Underrun: display time shorter than a shift.
    i_enable = 1'b0;
    cyc();
    check("dis_outs", {o_timer_en, o_fb_rd, o_sclk, o_latch, o_rgb}, 0);
    tmr_d = 4; tmr_b = 4;
    i_base_wait = 4'd4;
    i_enable = 1'b1;
    repeat (120) cyc();
    check("underrun_set", o_underrun, 1);
    repeat (3) begin
      repeat (20) cyc();
      check("underrun_sticky", o_underrun, 1);
    end
    i_enable = 1'b0;
    cyc();
    check("underrun_hold_idle", o_underrun, 1);
    cyc();
    check("underrun_clear", o_underrun, 0);

    // Disable in the middle of a shift, then restart with new config.
    tmr_d = 30; tmr_b = 4;
    i_base_wait = 4'd9;
    i_enable = 1'b1;
    n = 0;
    while (!o_timer_en && n < 60) begin cyc(); n++; end
    check("wait_ten", o_timer_en, 1);
    n = 0;
    while (!(o_fb_rd && o_fb_addr[2:0] == 3'd3) && n < 60) begin cyc(); n++; end
    check("wait_col3", o_fb_rd && o_fb_addr[2:0] == 3'd3, 1);
    i_enable = 1'b0;
    i_base_wait = 4'd7;
    i_blank_interval = 4'd2;
    cyc();
    check("mid_dis_outs", {o_timer_en, o_fb_rd, o_sclk, o_latch, o_rgb}, 0);
    check("mid_dis_cfg", o_base_wait, 9);
    i_enable = 1'b1;
    cyc();
    check("re_rd", o_fb_rd, 1);
    check("re_addr", o_fb_addr, 0);
    check("re_cfg", {o_base_wait, o_blank_interval}, {4'd7, 4'd2});
    check("re_ten", o_timer_en, 0);
    repeat (100) cyc();

    // Manual blank edges: at WAIT_BLANK entry, and on SHIFT's last cycle.
    i_enable = 1'b0;
    cyc();
    use_model = 1'b0;
    man_req = 1'b0;
    i_enable = 1'b1;
    n = 0;
    while (!o_timer_en && n < 60) begin cyc(); n++; end
    check("m_wait_ten", o_timer_en, 1);
    n = 0;
    while (!(o_sclk && !o_fb_rd) && n < 60) begin cyc(); n++; end
    check("m_wait_end", o_sclk && !o_fb_rd, 1);
    man_req = 1'b1;
    cyc();
    check("wb_entry_nolat", o_latch, 0);
    cyc();
    check("wb_entry_lat", o_latch, 1);
    check("wb_no_underrun", o_underrun, 0);
    man_req = 1'b0;
    n = 0;
    while (!(o_fb_rd && o_fb_addr[2:0] == 3'd7) && n < 60) begin cyc(); n++; end
    check("m_wait_col7", o_fb_rd && o_fb_addr[2:0] == 3'd7, 1);
    cyc();
    man_req = 1'b1;
    cyc();
    check("last_cyc_sclk", {o_sclk, o_fb_rd}, 2'b10);
    check("last_cyc_nolat", o_latch, 0);
    cyc();
    check("last_edge_lat", o_latch, 1);
    check("last_edge_underrun", o_underrun, 1);
    repeat (40) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
